// File: rtl/led_sequencer.sv
// LED animation sequencer: writable frame table played back at a programmable
// frame rate in loop, ping-pong, one-shot or hold mode.
module led_sequencer #(
  parameter int LED_W  = 8,
  parameter int ADDR_W = 3,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LED_W-1:0]  wr_data,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic [DIV_W-1:0]  frame_ticks,
  input  logic              run,
  output logic [LED_W-1:0]  leds,
  output logic [ADDR_W-1:0] frame_idx,
  output logic              frame_strobe,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_LOOP = 2'b00;
  localparam logic [1:0] M_PING = 2'b01;
  localparam logic [1:0] M_ONCE = 2'b10;

  localparam int DEPTH = 1 << ADDR_W;

  logic              rst_meta;
  logic              rst_sync;
  state_t            state_q, state_d;
  logic              dir_q, dir_d;       // 0 = counting up, 1 = counting down
  logic [DIV_W-1:0]  tick_q, tick_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              strobe;

  logic [LED_W-1:0]  mem [DEPTH];

  logic [DIV_W-1:0]  term_tick;
  logic              terminal;
  logic              at_end;
  logic [ADDR_W-1:0] turn_down_idx;
  logic [ADDR_W-1:0] turn_up_idx;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Frame table: plain synchronous write port, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A zero period behaves as one clock per frame; comparing with >= makes a
  // shortened period take effect on the very cycle it is applied.
  assign term_tick     = (frame_ticks == '0) ? '0 : frame_ticks - DIV_W'(1);
  assign terminal      = (tick_q >= term_tick);
  assign at_end        = (idx_q >= last_idx);
  assign turn_down_idx = (last_idx == '0) ? '0 : last_idx - ADDR_W'(1);
  assign turn_up_idx   = (last_idx == '0) ? '0 : ADDR_W'(1);

  // Control registers: state, direction, tick counter and frame index.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      tick_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: frame timing, index advance per mode, stop handling.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    strobe  = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d  = '0;
        dir_d  = 1'b0;
        tick_d = '0;
        if (run) state_d = PLAY;
      end
      PLAY: begin
        strobe = terminal;
        tick_d = terminal ? '0 : tick_q + DIV_W'(1);
        if (terminal) begin
          case (mode)
            M_LOOP: idx_d = at_end ? '0 : idx_q + ADDR_W'(1);
            M_PING: begin
              if (!dir_q) begin
                if (at_end) begin
                  dir_d = 1'b1;
                  idx_d = turn_down_idx;
                end else begin
                  idx_d = idx_q + ADDR_W'(1);
                end
              end else begin
                if (idx_q == '0) begin
                  dir_d = 1'b0;
                  idx_d = turn_up_idx;
                end else begin
                  idx_d = idx_q - ADDR_W'(1);
                end
              end
            end
            M_ONCE: begin
              if (at_end) state_d = DONE;
              else        idx_d   = idx_q + ADDR_W'(1);
            end
            default: idx_d = idx_q;
          endcase
        end
        // Stopping overrides any advance, but the strobe above still fires.
        if (!run) begin
          state_d = IDLE;
          idx_d   = '0;
          dir_d   = 1'b0;
          tick_d  = '0;
        end
      end
      DONE: begin
        tick_d = '0;
        if (!run) begin
          state_d = IDLE;
          idx_d   = '0;
          dir_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        dir_d   = 1'b0;
        tick_d  = '0;
      end
    endcase
  end

  // LED register shows the current frame one cycle after the index, blank when idle.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      leds <= '0;
    end else if (state_q == PLAY || state_q == DONE) begin
      leds <= mem[idx_q];
    end else begin
      leds <= '0;
    end
  end

  assign frame_idx    = idx_q;
  assign frame_strobe = strobe;
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: table of playback configurations plus
// hand-written sequences for stop, write collision, rate change and reset.
module tb_led_sequencer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  mode;
  logic [2:0]  last_idx;
  logic [23:0] frame_ticks;
  logic        run;
  logic [7:0]  leds;
  logic [2:0]  frame_idx;
  logic        frame_strobe;
  logic        done;

  int checks = 0;
  int errors = 0;

  led_sequencer #(.LED_W(8), .ADDR_W(3), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mode(mode), .last_idx(last_idx), .frame_ticks(frame_ticks), .run(run),
    .leds(leds), .frame_idx(frame_idx), .frame_strobe(frame_strobe), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  last;
    logic [23:0] ticks;
    int          ncyc;
    logic [2:0]  eidx;
    logic [7:0]  eleds;
    logic        estb;
    logic        edone;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] pattern [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic stop_and_idle(input string name);
    run = 1'b0;
    repeat (3) step();
    check({name, "_idle_idx"}, 32'(frame_idx), 32'd0);
    check({name, "_idle_leds"}, 32'(leds), 32'd0);
    check({name, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic start(input logic [1:0] m, input logic [2:0] l, input logic [23:0] t);
    mode        = m;
    last_idx    = l;
    frame_ticks = t;
    run         = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    pattern = '{8'h00, 8'h1E, 8'h3F, 8'h7E, 8'hFC, 8'h7E, 8'h3F, 8'h1E};
    //         mode   last  ticks  n   idx   leds   stb   done
    vecs[0]  = '{2'b00, 3'd7, 24'd4, 5,  3'd1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 3'd7, 24'd4, 16, 3'd3, 8'h7E, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 3'd7, 24'd4, 33, 3'd0, 8'h1E, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 3'd2, 24'd1, 6,  3'd2, 8'h1E, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 3'd3, 24'd1, 6,  3'd1, 8'h3F, 1'b1, 1'b0};
    vecs[5]  = '{2'b01, 3'd3, 24'd1, 9,  3'd2, 8'h1E, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 3'd0, 24'd1, 5,  3'd0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{2'b10, 3'd2, 24'd2, 6,  3'd2, 8'h3F, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 3'd2, 24'd2, 10, 3'd2, 8'h3F, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 3'd7, 24'd0, 3,  3'd2, 8'h1E, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 3'd7, 24'd3, 9,  3'd0, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 3'd5, 24'd2, 12, 3'd5, 8'h7E, 1'b1, 1'b0};

    rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    mode = 2'b00; last_idx = 3'd7; frame_ticks = 24'd4;
    repeat (3) step();
    check("reset_leds", 32'(leds), 32'd0);
    check("reset_idx", 32'(frame_idx), 32'd0);
    check("reset_strobe", 32'(frame_strobe), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = pattern[a];
      step();
    end
    wr_en = 1'b0;
    repeat (2) step();

    // Table-driven playback configurations.
    for (int v = 0; v < 12; v++) begin
      stop_and_idle($sformatf("v%0d", v));
      start(vecs[v].mode, vecs[v].last, vecs[v].ticks);
      repeat (vecs[v].ncyc) step();
      check($sformatf("v%0d_idx", v), 32'(frame_idx), 32'(vecs[v].eidx));
      check($sformatf("v%0d_leds", v), 32'(leds), 32'(vecs[v].eleds));
      check($sformatf("v%0d_strobe", v), 32'(frame_strobe), 32'(vecs[v].estb));
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].edone));
    end

    // One-shot finish, then dropping run clears done; leds blank a cycle later.
    stop_and_idle("once");
    start(2'b10, 3'd2, 24'd2);
    repeat (10) step();
    check("once_done_held", 32'(done), 32'd1);
    run = 1'b0;
    step();
    check("once_stop_done", 32'(done), 32'd0);
    check("once_stop_idx", 32'(frame_idx), 32'd0);
    check("once_stop_leds_lag", 32'(leds), 32'h3F);
    step();
    check("once_stop_leds_zero", 32'(leds), 32'd0);

    // Strobe cadence with a 4-clock frame.
    stop_and_idle("cad");
    start(2'b00, 3'd7, 24'd4);
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("cad_strobe_%0d", n), 32'(frame_strobe), 32'((n % 4) == 0));
    end

    // Shortening the period below the current tick ends the frame at once.
    stop_and_idle("rate");
    start(2'b00, 3'd7, 24'd8);
    repeat (6) step();
    check("rate_before", 32'(frame_strobe), 32'd0);
    frame_ticks = 24'd3;
    #1;
    check("rate_immediate", 32'(frame_strobe), 32'd1);
    step();
    check("rate_idx", 32'(frame_idx), 32'd1);
    check("rate_after", 32'(frame_strobe), 32'd0);

    // A strobe coinciding with run=0 is still emitted.
    stop_and_idle("stop");
    start(2'b00, 3'd7, 24'd1);
    repeat (3) step();
    check("stop_pre_idx", 32'(frame_idx), 32'd2);
    run = 1'b0;
    #1;
    check("stop_strobe_kept", 32'(frame_strobe), 32'd1);
    step();
    check("stop_idx", 32'(frame_idx), 32'd0);
    check("stop_strobe_gone", 32'(frame_strobe), 32'd0);

    // Write to the frame being displayed: old value first, new value next cycle.
    stop_and_idle("wr");
    start(2'b00, 3'd7, 24'd4);
    repeat (5) step();
    check("wr_idx", 32'(frame_idx), 32'd1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    check("wr_old", 32'(leds), 32'h1E);
    step();
    check("wr_new", 32'(leds), 32'hA5);
    wr_en = 1'b1; wr_data = 8'h1E;
    step();
    wr_en = 1'b0;

    // Reset in the middle of frame 5, then restart from frame 0.
    stop_and_idle("rst");
    start(2'b00, 3'd7, 24'd4);
    repeat (22) step();
    check("rst_pre_idx", 32'(frame_idx), 32'd5);
    check("rst_pre_leds", 32'(leds), 32'h7E);
    rst = 1'b1;
    #1;
    check("rst_async_leds", 32'(leds), 32'd0);
    check("rst_async_idx", 32'(frame_idx), 32'd0);
    check("rst_async_strobe", 32'(frame_strobe), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (frame_strobe) found = 1'b1;
    end
    check("rst_restart_strobe_seen", 32'(found), 32'd1);
    check("rst_restart_idx0", 32'(frame_idx), 32'd0);
    step();
    check("rst_restart_idx1", 32'(frame_idx), 32'd1);
    check("rst_restart_leds", 32'(leds), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Parametrised LED animation sequencer for the iCE40 example designs: a writable frame table of LED patterns, played back at a programmable frame rate. Supports loop, ping-pong, one-shot and hold playback modes, and reports frame boundaries and completion. Drives an LED bank directly; the table is loaded by a host, UART bridge or init FSM.

Parameters:
LED_W, 8, LED bank width (bits per frame)
ADDR_W, 3, frame index width; table depth = 2**ADDR_W
DIV_W, 24, width of the frame-period counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  frame-table write strobe
wr_addr  input  ADDR_W  frame-table write address
wr_data  input  LED_W  frame-table write data
mode  input  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold
last_idx  input  ADDR_W  index of the final frame in the sequence
frame_ticks  input  DIV_W  clocks per frame; 0 treated as 1
run  input  1  level: 1 = play, 0 = stop and return to idle
leds  output  LED_W  registered LED pattern
frame_idx  output  ADDR_W  current frame index
frame_strobe  output  1  one-cycle pulse at each frame-period expiry
done  output  1  high while one-shot playback has finished

Behaviour:
- One clock domain, `clk`. Reset is asynchronous and active-high on `rst`; it is synchronised for deassertion.
- Reset values:
  - state = IDLE, dir = up, tick counter = 0
  - leds = 0, frame_idx = 0, frame_strobe = 0, done = 0
  - The frame table is not reset; its contents are undefined until written.
- Frame table:
  - Synchronous write. A write with wr_en=1 lands at the clock edge, so a read of that address in the same cycle returns the old data.
  - Writes are accepted in every state.
- leds register:
  - Each cycle, leds <= table[frame_idx] in PLAY and DONE, and leds <= 0 in IDLE.
  - leds lags frame_idx by one cycle.
- IDLE:
  - With run=1, the next state is PLAY, with frame_idx=0, dir=up and tick=0.
- PLAY:
  - tick counts 0..max(frame_ticks,1)-1.
  - At the terminal count: tick <= 0, frame_strobe = 1 for that single cycle, and frame_idx advances according to mode. mode is sampled at each advance.
  - Below, "at the end" means frame_idx >= last_idx.
  - loop: at the end, frame_idx <= 0; otherwise frame_idx + 1.
  - ping-pong, dir up: at the end, set dir=down and frame_idx <= last_idx-1 (0 if last_idx=0); otherwise +1.
  - ping-pong, dir down: at frame_idx=0, set dir=up and frame_idx <= 1 (0 if last_idx=0); otherwise -1.
  - one-shot: at the end, go to DONE with done=1 and frame_idx unchanged; otherwise +1.
  - hold: frame_idx unchanged; frame_strobe still pulses.
  - frame_ticks changes take effect immediately. If tick >= the new period, the current cycle counts as the terminal count.
- DONE:
  - leds keeps showing the final frame and no strobes are produced.
  - run=0 leads to IDLE.
- Stopping from any state:
  - run=0 in PLAY or DONE returns to IDLE on the next edge: frame_idx=0, done=0, tick=0, dir=up.
  - leds reads 0 one cycle later.
  - A strobe that coincides with run=0 is still emitted in that cycle.
- Reset mid-operation immediately forces all reset values, regardless of state.

Test Plan:
- Load table with 00,1E,3F,7E,FC,7E,3F,1E; mode=00, last_idx=7, frame_ticks=4, run=1 → frame_idx visits 0..7 then 0, with a strobe every 4 clocks; leds follows the table one cycle behind.
- mode=01, last_idx=3, frame_ticks=1 → frame_idx sequence 0,1,2,3,2,1,0,1,…; with last_idx=0 it stays at 0.
- mode=10, last_idx=2, frame_ticks=2 → frames 0,1,2, then done=1 and leds=3F held. Dropping run clears done, and leds=0 two cycles later.
- frame_ticks=0 → a strobe every clock.
- Write to address 1 while frame_idx=1 → leds shows the old value that cycle and the new value the following cycle.
- Assert rst mid-PLAY at frame 5 → outputs go to zero asynchronously. After release with run=1, playback restarts at frame 0.
